// File: rtl/target_pin_arbiter.sv
// target_pin_arbiter: hands the shared target programming pins to one of three requesters,
// with tri-state guard intervals on every handover, an optional hold limit and a power-off override.
module target_pin_arbiter #(
   parameter int unsigned GUARD_CYCLES = 4,
   parameter int unsigned MAX_HOLD     = 0
) (
   input  logic       clk,
   input  logic       reset_i,
   input  logic [2:0] req,
   input  logic       target_highz,
   input  logic       clear_stats,
   output logic [2:0] grant,
   output logic       pin_oe,
   output logic [1:0] pin_sel,
   output logic       busy,
   output logic [2:0] state_o,
   output logic [7:0] denied_cnt,
   output logic       timeout_flag
);
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      GUARD_IN  = 3'd1,
      OWNED     = 3'd2,
      GUARD_OUT = 3'd3,
      HIGHZ     = 3'd4
   } state_e;

   localparam logic [7:0]  GC  = 8'(GUARD_CYCLES);
   localparam logic [15:0] MH1 = 16'(MAX_HOLD - 1);

   state_e      state_q, state_d;
   logic [7:0]  gcnt_q, gcnt_d;
   logic [15:0] hold_q, hold_d;
   logic [1:0]  owner_q, owner_d;
   logic [2:0]  mask_q, mask_d;
   logic [2:0]  req_q;
   logic [2:0]  elig, win, denied;
   logic        timeout;
   logic [1:0]  n_denied;
   logic [8:0]  den_sum;
   logic [7:0]  den_d;
   logic        tf_d;

   always_comb begin
      state_d = state_q;
      gcnt_d  = gcnt_q;
      hold_d  = hold_q;
      owner_d = owner_q;
      win     = 3'b000;
      timeout = 1'b0;
      elig    = req & ~mask_q;
      if (target_highz) begin
         state_d = HIGHZ;
      end else begin
         case (state_q)
            IDLE: if (|elig) begin
               owner_d = elig[2] ? 2'd2 : (elig[1] ? 2'd1 : 2'd0);
               win     = 3'b001 << owner_d;
               gcnt_d  = GC;
               state_d = GUARD_IN;
            end
            GUARD_IN: if (!req[owner_q]) begin
               state_d = GUARD_OUT;
               gcnt_d  = GC;
            end else if (gcnt_q == 8'd0) begin
               state_d = OWNED;
               hold_d  = 16'd0;
            end else begin
               gcnt_d = gcnt_q - 8'd1;
            end
            OWNED: if (!req[owner_q]) begin
               state_d = GUARD_OUT;
               gcnt_d  = GC;
            end else if (MAX_HOLD != 0 && hold_q == MH1) begin
               timeout = 1'b1;
               state_d = GUARD_OUT;
               gcnt_d  = GC;
            end else begin
               hold_d = hold_q + 16'd1;
            end
            // a zero-length guard still spends one cycle here before IDLE
            GUARD_OUT: if (gcnt_q <= 8'd1) state_d = IDLE;
               else gcnt_d = gcnt_q - 8'd1;
            HIGHZ: begin
               state_d = GUARD_OUT;
               gcnt_d  = GC;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign mask_d   = (mask_q & req) | (timeout ? (3'b001 << owner_q) : 3'b000);
   assign denied   = req & ~req_q & ~win;
   assign n_denied = {1'b0, denied[0]} + {1'b0, denied[1]} + {1'b0, denied[2]};
   assign den_sum  = {1'b0, denied_cnt} + {7'b0, n_denied};
   assign den_d    = clear_stats ? 8'd0 : (den_sum[8] ? 8'hFF : den_sum[7:0]);
   assign tf_d     = ~clear_stats & (timeout_flag | timeout);

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q      <= IDLE;
         gcnt_q       <= 8'd0;
         hold_q       <= 16'd0;
         owner_q      <= 2'd0;
         mask_q       <= 3'b000;
         req_q        <= 3'b000;
         grant        <= 3'b000;
         pin_oe       <= 1'b0;
         pin_sel      <= 2'd0;
         busy         <= 1'b0;
         state_o      <= 3'd0;
         denied_cnt   <= 8'd0;
         timeout_flag <= 1'b0;
      end else begin
         state_q      <= state_d;
         gcnt_q       <= gcnt_d;
         hold_q       <= hold_d;
         owner_q      <= owner_d;
         mask_q       <= mask_d;
         req_q        <= req;
         grant        <= (state_q == OWNED) ? (3'b001 << owner_q) : 3'b000;
         pin_oe       <= state_q == OWNED;
         pin_sel      <= owner_q;
         busy         <= state_q != IDLE;
         state_o      <= state_q;
         denied_cnt   <= den_d;
         timeout_flag <= tf_d;
      end
   end
endmodule
